// File: rtl/uart_pkg.sv
// Shared UART receive definitions: deserializer state encoding and default timing.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 25_000_000;
  localparam int DEF_BAUD     = 115_200;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead byte FIFO. The head entry is always presented on rd_data.
// A push while full is accepted only if the same cycle also pops.
module rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];

  // Qualify requests: pops need data, pushes need room (a same-cycle pop frees it).
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array carries no reset; contents are only observed when count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead FIFO, with sticky frame/overflow flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rxd,
  output logic [7:0]             rx_data,
  output logic                   rx_data_ready,
  input  logic                   rx_data_accept,
  input  logic                   err_clr,
  output logic                   rx_frame_err,
  output logic                   rx_overflow,
  output logic [$clog2(DEPTH):0] rx_count
);

  localparam int BIT_DIV  = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BIT_DIV / 2;
  localparam int CNT_W    = $clog2(BIT_DIV + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic fall;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_tick;

  logic frame_err_q, frame_err_d;
  logic overflow_q, overflow_d;
  logic push, pop, fifo_full, fifo_empty;

  // Two-flop synchronizer plus a history flop for falling-edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Only a true 1->0 transition starts a frame, so a line stuck low never retriggers.
  assign fall = rxd_prev_q & ~rxd_sync_q;

  // Deserializer next state: mid-bit sampling, LSB first, stop sample raises stop_tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    stop_tick = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid-start means a glitch: silently abandon.
          state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          stop_tick = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Deserializer registers; reset drops any partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign pop  = rx_data_accept & ~fifo_empty;
  assign push = stop_tick & rxd_sync_q;

  // Sticky flags: a set event in the same cycle as err_clr wins.
  always_comb begin
    frame_err_d = (stop_tick & ~rxd_sync_q) | (frame_err_q & ~err_clr);
    overflow_d  = (push & fifo_full & ~pop) | (overflow_q & ~err_clr);
  end

  // Flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .rd_data   (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_count)
  );

  assign rx_data_ready = ~fifo_empty;
  assign rx_frame_err  = frame_err_q;
  assign rx_overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default timing (217 clocks per bit, DEPTH 4).
module tb_uart_rx_fifo;

  localparam int BITC = 217;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_data_accept;
  logic       err_clr;
  logic       rx_frame_err;
  logic       rx_overflow;
  logic [2:0] rx_count;

  int vectors = 0;
  int errs    = 0;

  uart_rx_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rxd       (uart_rxd),
    .rx_data        (rx_data),
    .rx_data_ready  (rx_data_ready),
    .rx_data_accept (rx_data_accept),
    .err_clr        (err_clr),
    .rx_frame_err   (rx_frame_err),
    .rx_overflow    (rx_overflow),
    .rx_count       (rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; drives a full 10-bit frame and returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    uart_rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    uart_rxd = stop_lvl;
    repeat (BITC) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_rdy"}, rx_data_ready, 1'b1);
    chk({tag, "_data"}, rx_data, exp);
    rx_data_accept = 1'b1;
    @(negedge clk);
    rx_data_accept = 1'b0;
  endtask

  initial begin
    rst = 1'b1; uart_rxd = 1'b1; rx_data_accept = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", rx_count, 3'd0);
    chk("rst_ready", rx_data_ready, 1'b0);
    chk("rst_ferr", rx_frame_err, 1'b0);
    chk("rst_ovf", rx_overflow, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single byte; stop sample lands on the 2064th rising edge after the start bit is driven.
    fork
      send_byte(8'h55, 1'b1);
      begin
        repeat (2063) @(posedge clk);
        @(negedge clk);
        chk("b55_before_ready", rx_data_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("b55_ready", rx_data_ready, 1'b1);
        chk("b55_data", rx_data, 8'h55);
        chk("b55_count", rx_count, 3'd1);
      end
    join
    pop_chk("b55_pop", 8'h55);
    chk("b55_empty", rx_count, 3'd0);
    chk("b55_empty_rdy", rx_data_ready, 1'b0);

    // Accept on an empty FIFO is ignored.
    rx_data_accept = 1'b1;
    repeat (3) @(negedge clk);
    rx_data_accept = 1'b0;
    chk("empty_accept_count", rx_count, 3'd0);

    // Five back-to-back bytes, no accept: fifth is dropped with overflow.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    repeat (5) @(negedge clk);
    chk("ovf_count", rx_count, 3'd4);
    chk("ovf_flag", rx_overflow, 1'b1);
    chk("ovf_ferr", rx_frame_err, 1'b0);
    for (int i = 1; i <= 4; i++) pop_chk("ovf_pop", 8'(i));
    chk("ovf_drained", rx_count, 3'd0);
    chk("ovf_sticky", rx_overflow, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_clr", rx_overflow, 1'b0);

    // Frame error: stop bit low.
    send_byte(8'hA3, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_count", rx_count, 3'd0);
    chk("ferr_flag", rx_frame_err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ferr_clr", rx_frame_err, 1'b0);
    repeat (10) @(negedge clk);

    // 50-cycle glitch on an idle line.
    uart_rxd = 1'b0;
    repeat (50) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_count", rx_count, 3'd0);
    chk("glitch_ferr", rx_frame_err, 1'b0);
    chk("glitch_ovf", rx_overflow, 1'b0);
    send_byte(8'h96, 1'b1);
    repeat (5) @(negedge clk);
    chk("glitch_next_count", rx_count, 3'd1);
    pop_chk("glitch_next", 8'h96);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x3C.
    uart_rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4 * BITC + 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4 * BITC) @(negedge clk);
    chk("midrst_count", rx_count, 3'd0);
    send_byte(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    chk("midrst_rx_count", rx_count, 3'd1);
    pop_chk("midrst_rx", 8'h3C);
    chk("midrst_empty", rx_count, 3'd0);

    // Full FIFO plus pop on the exact stop-sample cycle of a fifth byte.
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h40, 1'b1);
    chk("full_count", rx_count, 3'd4);
    fork
      send_byte(8'h50, 1'b1);
      begin
        repeat (2063) @(posedge clk);
        @(negedge clk);
        rx_data_accept = 1'b1;
        @(negedge clk);
        rx_data_accept = 1'b0;
        chk("pushpop_count", rx_count, 3'd4);
        chk("pushpop_ovf", rx_overflow, 1'b0);
      end
    join
    pop_chk("pushpop_a", 8'h20);
    pop_chk("pushpop_b", 8'h30);
    pop_chk("pushpop_c", 8'h40);
    pop_chk("pushpop_d", 8'h50);
    chk("pushpop_empty", rx_count, 3'd0);
    chk("pushpop_ovf_end", rx_overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
